// File: rtl/cache_control_nway_pkg.sv
// Shared types for the n-way cache controller.
// Controller FSM states and the default line width.
package lc3b_types;

  localparam int CACHE_LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    WRITE_BACK,
    ALLOCATE
  } ctrl_state_t;

endpackage

// File: rtl/cache_control_nway_plru.sv
// Combinational tree pseudo-LRU for one set, heap-ordered node bits.
// A 0 node bit means the victim lies on the lower-index side.
module plru_tree #(
  parameter  int WAYS  = 4,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  bits,
  input  logic [WAY_W-1:0] access_way,
  output logic [WAY_W-1:0] victim_way,
  output logic [WAYS-2:0]  updated_bits
);

  logic [WAY_W-1:0] w_nv;
  logic [WAY_W-1:0] w_nu;
  logic [WAYS-2:0]  w_upd;

  // Walk root to leaf; way index bits come out MSB first.
  always_comb begin
    victim_way = '0;
    w_upd      = bits;
    w_nv       = '0;
    w_nu       = '0;
    for (int l = 0; l < WAY_W; l++) begin
      victim_way[WAY_W-1-l] = bits[w_nv];
      w_nv = WAY_W'({w_nv, 1'b1}
           + {{WAY_W{1'b0}}, bits[w_nv]});
      w_upd[w_nu] = ~access_way[WAY_W-1-l];
      w_nu = WAY_W'({w_nu, 1'b1}
           + {{WAY_W{1'b0}}, access_way[WAY_W-1-l]});
    end
  end

  assign updated_bits = w_upd;

endmodule

// File: rtl/cache_control_nway.sv
// WAYS-way write-back/write-allocate cache controller FSM.
// Optional perf counters: define CACHE_CTRL_PERF_EN.
module cache_control_nway
  import lc3b_types::*;
#(
  parameter  int WAYS   = 4,
  parameter  int LINE_W = CACHE_LINE_W,
  localparam int WAY_W  = $clog2(WAYS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [WAYS-1:0]        hit_vec,
  input  logic [WAYS-1:0]        valid_vec,
  input  logic [WAYS-1:0]        dirty_vec,
  input  logic [WAYS-2:0]        plru_in,
  input  logic [WAYS*LINE_W-1:0] line_data,
  input  logic                   pmem_resp,
  output logic [WAYS-2:0]        plru_out,
  output logic                   plru_write,
  output logic [WAYS-1:0]        way_write,
  output logic                   valid_in,
  output logic                   dirty_in,
  output logic                   alloc_sel,
  output logic                   wb_addr_sel,
  output logic [WAY_W-1:0]       victim,
  output logic                   mem_resp,
  output logic                   pmem_read,
  output logic                   pmem_write,
  output logic [LINE_W-1:0]      pmem_wdata
`ifdef CACHE_CTRL_PERF_EN
  ,
  output logic [31:0]            perf_hits,
  output logic [31:0]            perf_misses,
  output logic [31:0]            perf_wbacks
`endif
);

  ctrl_state_t r_state;
  ctrl_state_t w_next;

  logic [WAY_W-1:0] r_victim;
  logic [WAY_W-1:0] w_hit_way;
  logic [WAY_W-1:0] w_inv_way;
  logic [WAY_W-1:0] w_plru_vic;
  logic [WAY_W-1:0] w_miss_way;
  logic [WAY_W-1:0] w_unused_vic;
  logic [WAYS-2:0]  w_plru_upd;
  logic [WAYS-2:0]  w_unused_upd;
  logic [WAYS-1:0]  w_one;
  logic             w_any_inv;
  logic             w_req;
  logic             w_hit;
  logic             w_hit_rsp;
  logic             w_miss;
  logic             w_wb_done;

  assign w_one     = {{(WAYS-1){1'b0}}, 1'b1};
  assign w_req     = mem_read ^ mem_write;
  assign w_hit     = |hit_vec;
  assign w_hit_rsp = (r_state == IDLE) && w_req && w_hit;
  assign w_miss    = (r_state == IDLE) && w_req && !w_hit;
  assign w_wb_done = (r_state == WRITE_BACK) && pmem_resp;

  always_comb begin
    w_hit_way = '0;
    w_inv_way = '0;
    w_any_inv = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) w_hit_way = i[WAY_W-1:0];
      if (!valid_vec[i]) begin
        w_inv_way = i[WAY_W-1:0];
        w_any_inv = 1'b1;
      end
    end
  end

  plru_tree #(.WAYS(WAYS)) u_vic (
    .bits         (plru_in),
    .access_way   (r_victim),
    .victim_way   (w_plru_vic),
    .updated_bits (w_unused_upd)
  );

  plru_tree #(.WAYS(WAYS)) u_upd (
    .bits         (plru_in),
    .access_way   (w_hit_way),
    .victim_way   (w_unused_vic),
    .updated_bits (w_plru_upd)
  );

  // Refill an empty way before evicting anything.
  assign w_miss_way = w_any_inv ? w_inv_way : w_plru_vic;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_victim <= '0;
    end else begin
      r_state <= w_next;
      if (w_miss) r_victim <= w_miss_way;
    end
  end

  always_comb begin
    w_next      = r_state;
    plru_out    = '0;
    plru_write  = 1'b0;
    way_write   = '0;
    valid_in    = 1'b0;
    dirty_in    = 1'b0;
    alloc_sel   = 1'b0;
    wb_addr_sel = 1'b0;
    mem_resp    = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req && w_hit) begin
          mem_resp   = 1'b1;
          plru_write = 1'b1;
          plru_out   = w_plru_upd;
          if (mem_write) begin
            way_write = w_one << w_hit_way;
            valid_in  = 1'b1;
            dirty_in  = 1'b1;
          end
        end else if (w_req) begin
          if (valid_vec[w_miss_way] && dirty_vec[w_miss_way])
            w_next = WRITE_BACK;
          else
            w_next = ALLOCATE;
        end
      end
      WRITE_BACK: begin
        pmem_write  = 1'b1;
        wb_addr_sel = 1'b1;
        if (pmem_resp) w_next = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        alloc_sel = 1'b1;
        way_write = w_one << r_victim;
        valid_in  = 1'b1;
        if (pmem_resp) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign victim     = r_victim;
  assign pmem_wdata = line_data[r_victim*LINE_W +: LINE_W];

`ifdef CACHE_CTRL_PERF_EN
  logic [31:0] r_hits;
  logic [31:0] r_misses;
  logic [31:0] r_wbacks;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hits   <= '0;
      r_misses <= '0;
      r_wbacks <= '0;
    end else begin
      if (w_hit_rsp && r_hits != '1)
        r_hits <= r_hits + 32'd1;
      if (w_miss && r_misses != '1)
        r_misses <= r_misses + 32'd1;
      if (w_wb_done && r_wbacks != '1)
        r_wbacks <= r_wbacks + 32'd1;
    end
  end

  assign perf_hits   = r_hits;
  assign perf_misses = r_misses;
  assign perf_wbacks = r_wbacks;
`else
  logic w_unused_perf;
  assign w_unused_perf = w_hit_rsp ^ w_wb_done;
`endif

endmodule

// File: tb/tb_cache_control_nway.sv
// Scoreboard bench for cache_control_nway, WAYS=4, LINE_W=128.
// Directed vectors; a negedge monitor pops expected output snapshots.
module tb_cache_control_nway;

  typedef struct packed {
    logic         resp;
    logic         plw;
    logic [2:0]   plo;
    logic [3:0]   ww;
    logic         vi;
    logic         di;
    logic         as;
    logic         wb;
    logic [1:0]   vic;
    logic         pr;
    logic         pw;
    logic [127:0] wd;
  } obs_t;

  typedef struct {
    obs_t  o;
    string nm;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_read, mem_write;
  logic [3:0]   hit_vec, valid_vec, dirty_vec;
  logic [2:0]   plru_in;
  logic [511:0] line_data;
  logic         pmem_resp;
  logic [2:0]   plru_out;
  logic         plru_write;
  logic [3:0]   way_write;
  logic         valid_in, dirty_in, alloc_sel, wb_addr_sel;
  logic [1:0]   victim;
  logic         mem_resp, pmem_read, pmem_write;
  logic [127:0] pmem_wdata;
`ifdef CACHE_CTRL_PERF_EN
  logic [31:0]  perf_hits, perf_misses, perf_wbacks;
`endif

  logic [127:0] L [4];
  exp_t         exp_q [$];
  int           n_chk = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  cache_control_nway #(.WAYS(4), .LINE_W(128)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .hit_vec     (hit_vec),
    .valid_vec   (valid_vec),
    .dirty_vec   (dirty_vec),
    .plru_in     (plru_in),
    .line_data   (line_data),
    .pmem_resp   (pmem_resp),
    .plru_out    (plru_out),
    .plru_write  (plru_write),
    .way_write   (way_write),
    .valid_in    (valid_in),
    .dirty_in    (dirty_in),
    .alloc_sel   (alloc_sel),
    .wb_addr_sel (wb_addr_sel),
    .victim      (victim),
    .mem_resp    (mem_resp),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_wdata  (pmem_wdata)
`ifdef CACHE_CTRL_PERF_EN
    ,
    .perf_hits   (perf_hits),
    .perf_misses (perf_misses),
    .perf_wbacks (perf_wbacks)
`endif
  );

  function automatic obs_t snap();
    obs_t a;
    a = '{mem_resp, plru_write, plru_out, way_write,
          valid_in, dirty_in, alloc_sel, wb_addr_sel,
          victim, pmem_read, pmem_write, pmem_wdata};
    return a;
  endfunction

  function automatic obs_t mk(
    input logic rs, pw_, input logic [2:0] plo,
    input logic [3:0] ww, input logic vi, di, as, wb,
    input logic [1:0] vic, input logic pr, pw);
    obs_t e;
    e = '{rs, pw_, plo, ww, vi, di, as, wb,
          vic, pr, pw, L[vic]};
    return e;
  endfunction

  function automatic obs_t q(input logic [1:0] vic);
    return mk(0, 0, 3'b000, 4'b0000, 0, 0, 0, 0, vic, 0, 0);
  endfunction

  // Monitor: any activity on the DUT outputs consumes one expectation.
  always @(negedge clk) begin
    obs_t a;
    exp_t e;
    if (rst_n) begin
      a = snap();
      if (a.resp || a.plw || (|a.ww) || a.pr || a.pw) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output got=%h", a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e.o) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", e.nm, a, e.o);
          end
        end
      end
    end
  end

  // Called at posedge+1; quiet cycles are checked here at the negedge.
  task automatic step(
    input logic rd, wr, input logic [3:0] hv, vv, dv,
    input logic [2:0] pl, input logic pr, input bit act,
    input obs_t e, input string nm);
    obs_t a;
    exp_t x;
    mem_read  = rd;
    mem_write = wr;
    hit_vec   = hv;
    valid_vec = vv;
    dirty_vec = dv;
    plru_in   = pl;
    pmem_resp = pr;
    if (act) begin
      x.o  = e;
      x.nm = nm;
      exp_q.push_back(x);
    end
    @(negedge clk);
    if (!act) begin
      a = snap();
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s got=%h want=%h", nm, a, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

`ifdef CACHE_CTRL_PERF_EN
  task automatic chk_perf(input int h, m, w, input string nm);
    n_chk++;
    if (perf_hits !== 32'(h) || perf_misses !== 32'(m)
        || perf_wbacks !== 32'(w)) begin
      n_fail++;
      $display("FAIL %s got=%0d/%0d/%0d want=%0d/%0d/%0d", nm,
               perf_hits, perf_misses, perf_wbacks, h, m, w);
    end
  endtask
`endif

  initial begin
    obs_t e;
    for (int w = 0; w < 4; w++) begin
      L[w] = {4{32'hA5A5_0000 + 32'(w)}};
      line_data[w*128 +: 128] = L[w];
    end
    rst_n = 1'b0;
    mem_read = 0; mem_write = 0; pmem_resp = 0;
    hit_vec = 0; valid_vec = 0; dirty_vec = 0; plru_in = 0;
    @(negedge clk);
    n_chk++;
    if (snap() !== q(2'd0)) begin
      n_fail++;
      $display("FAIL reset got=%h want=%h", snap(), q(2'd0));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    step(1, 0, 4'b0001, 4'b1111, 4'b0000, 3'b000, 0, 1,
         mk(1, 1, 3'b011, 4'b0000, 0, 0, 0, 0, 0, 0, 0), "rd_hit");
    step(0, 1, 4'b0100, 4'b1111, 4'b0000, 3'b000, 0, 1,
         mk(1, 1, 3'b100, 4'b0100, 1, 1, 0, 0, 0, 0, 0), "wr_hit");
    step(1, 1, 4'b0001, 4'b1111, 4'b0000, 3'b000, 0, 0,
         q(2'd0), "both_req");
    step(0, 0, 4'b0001, 4'b1111, 4'b0000, 3'b000, 0, 0,
         q(2'd0), "no_req");

    // Clean miss, all valid, PLRU -> way 0; mid-miss inputs scrambled.
    step(1, 0, 4'b0000, 4'b1111, 4'b0000, 3'b000, 0, 0,
         q(2'd0), "miss_clean");
    e = mk(0, 0, 3'b000, 4'b0001, 1, 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++)
      step(1, 0, 4'b0000, 4'b1111, 4'b1111, 3'b111, 0, 1,
           e, "alloc_wait");
    step(1, 0, 4'b0000, 4'b1111, 4'b1111, 3'b111, 1, 1,
         e, "alloc_done");
    step(1, 0, 4'b0001, 4'b1111, 4'b0000, 3'b000, 0, 1,
         mk(1, 1, 3'b011, 4'b0000, 0, 0, 0, 0, 0, 0, 0), "fill_hit");

    // Invalid way first: way 2 empty though PLRU names way 0.
    step(1, 0, 4'b0000, 4'b1011, 4'b1111, 3'b000, 0, 0,
         q(2'd0), "miss_inv");
    step(1, 0, 4'b0000, 4'b1011, 4'b1111, 3'b000, 1, 1,
         mk(0, 0, 3'b000, 4'b0100, 1, 0, 1, 0, 2, 1, 0), "alloc_inv");

    // Way 1 empty overrides a dirty PLRU victim (way 2).
    step(1, 0, 4'b0000, 4'b1101, 4'b0100, 3'b011, 0, 0,
         q(2'd2), "miss_inv2");
    step(1, 0, 4'b0000, 4'b1101, 4'b0100, 3'b011, 1, 1,
         mk(0, 0, 3'b000, 4'b0010, 1, 0, 1, 0, 1, 1, 0), "alloc_inv2");

    // Dirty miss: PLRU 011 -> way 2, dirty -> write-back first.
    step(1, 0, 4'b0000, 4'b1111, 4'b0100, 3'b011, 0, 0,
         q(2'd1), "miss_dirty");
    e = mk(0, 0, 3'b000, 4'b0000, 0, 0, 0, 1, 2, 0, 1);
    for (int i = 0; i < 2; i++)
      step(1, 0, 4'b0000, 4'b1111, 4'b0000, 3'b000, 0, 1,
           e, "wb_wait");
    step(1, 0, 4'b0000, 4'b1111, 4'b0000, 3'b000, 1, 1,
         e, "wb_done");
    e = mk(0, 0, 3'b000, 4'b0100, 1, 0, 1, 0, 2, 1, 0);
    step(1, 0, 4'b0000, 4'b1111, 4'b0000, 3'b000, 0, 1,
         e, "alloc_wb");
    step(1, 0, 4'b0000, 4'b1111, 4'b0000, 3'b000, 1, 1,
         e, "alloc_wb_done");
    step(1, 0, 4'b0100, 4'b1111, 4'b0000, 3'b011, 0, 1,
         mk(1, 1, 3'b110, 4'b0000, 0, 0, 0, 0, 2, 0, 0), "wb_hit");
`ifdef CACHE_CTRL_PERF_EN
    chk_perf(4, 4, 1, "perf_run");
`endif

    // Dirty miss to way 3, then async reset inside WRITE_BACK.
    step(1, 0, 4'b0000, 4'b1111, 4'b1000, 3'b111, 0, 0,
         q(2'd2), "miss_dirty3");
    step(1, 0, 4'b0000, 4'b1111, 4'b1000, 3'b111, 0, 1,
         mk(0, 0, 3'b000, 4'b0000, 0, 0, 0, 1, 3, 0, 1), "wb3");
    mem_read  = 0;
    exp_q.push_back('{mk(0, 0, 3'b000, 4'b0000, 0, 0, 0, 1, 3, 0, 1),
                      "wb3_hold"});
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (snap() !== q(2'd0)) begin
      n_fail++;
      $display("FAIL rst_async got=%h want=%h", snap(), q(2'd0));
    end
`ifdef CACHE_CTRL_PERF_EN
    chk_perf(0, 0, 0, "perf_rst");
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 0, 4'b0010, 4'b1111, 4'b0000, 3'b000, 0, 1,
         mk(1, 1, 3'b001, 4'b0000, 0, 0, 0, 0, 0, 0, 0), "rst_hit");
`ifdef CACHE_CTRL_PERF_EN
    chk_perf(1, 0, 0, "perf_after");
`endif
    step(0, 0, 4'b0000, 4'b1111, 4'b0000, 3'b000, 0, 0,
         q(2'd0), "idle_end");

    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got=%0d want=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
